atm_session_timeout_ctrl: RTL
=============================

Name: atm_session_timeout_ctrl

Overview:
- Sequences the inactivity timeout for one ATM customer session.
- Owns a single cycle counter and reloads it with a phase-specific limit: PIN entry, menu, or cash collection.
- Restarts the counter on keypad activity and raises a warning before aborting the session.
- Sits between the ATM main FSM, the keypad front end and the card/cash mechanics, and drives the abort request that ejects the card or retracts cash.

Parameters:
- CNT_W, 32: counter and limit width.
- PIN_LIMIT, 32'd30000000: cycles allowed in PIN phase before warning.
- MENU_LIMIT, 32'd60000000: cycles allowed in MENU phase before warning.
- CASH_LIMIT, 32'd30000000: cycles allowed for cash collection before abort. No warning in this phase.
- WARN_LIMIT, 32'd10000000: length of the warning window.
- All limits must be >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-low reset.
- card_in, input, 1: level; card present in reader.
- key_event, input, 1: pulse; any keypad press.
- pin_ok, input, 1: pulse; PIN verified.
- cash_presented, input, 1: pulse; dispenser has presented notes.
- cash_taken, input, 1: pulse; notes removed.
- active, output, 1: session timing in progress.
- phase, output, 3: current FSM state encoding.
- timeout_warn, output, 1: high throughout WARN.
- session_abort, output, 1: one-cycle pulse on expiry.
- abort_cause, output, 2: 0 none, 1 PIN, 2 MENU, 3 CASH.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, count=0, resume=PIN.
  - All outputs 0.
  - Reset mid-session drops everything; no abort is issued.
- States: IDLE, PIN, MENU, CASH, WARN, EJECT.
- Counter:
  - count is cleared on every state entry and on every restart.
  - Otherwise it increments by 1 each cycle in PIN, MENU, CASH and WARN.
  - Expiry is when count == limit-1 for the current state, i.e. exactly LIMIT cycles after entry or restart.
  - The counter never wraps.
- Transitions:
  - IDLE -> PIN when card_in=1. Clears abort_cause.
  - PIN: pin_ok -> MENU. Expiry -> WARN with resume=PIN.
  - MENU: cash_presented -> CASH. Expiry -> WARN with resume=MENU.
  - CASH: cash_taken -> MENU. Expiry -> EJECT with session_abort=1 and abort_cause=3. key_event is ignored here.
  - WARN: key_event -> resume state with count=0. Expiry -> EJECT with session_abort=1 and abort_cause = resume (PIN=1, MENU=2).
  - EJECT: waits for card_in=0, then goes to IDLE.
- Restart: key_event in PIN or MENU clears count and the state is kept.
- Priority within a cycle, highest first:
  1. rst
  2. card_in=0, which sends every non-IDLE state to IDLE next cycle with no abort
  3. phase event (pin_ok, cash_presented, cash_taken)
  4. key_event
  5. expiry
- Consequence of the priority rule: key_event in the same cycle as expiry restarts the counter; no warning or abort is raised.
- Output timing:
  - Outputs are registered, so state changes are visible the cycle after the causing input.
  - session_abort is asserted for exactly 1 cycle, coincident with entry to EJECT.
  - abort_cause holds its value through EJECT and IDLE until the next session starts.
- active=1 in PIN, MENU, CASH and WARN.
- timeout_warn equals (state==WARN), registered.
- Phase events outside their own state are ignored, e.g. pin_ok in MENU.

Decomposition:
- Shared package atm_timeout_pkg holds:
  - state enum/localparams (IDLE=0, PIN=1, MENU=2, CASH=3, WARN=4, EJECT=5);
  - abort cause codes;
  - CNT_W.
- One sub-module, atm_cycle_counter (CNT_W), with inputs clear, enable and limit and output expired (count==limit-1, combinational).
  - Uses the same synchronous active-low rst.
  - The FSM selects the limit via a mux on state.

Test Plan (params PIN_LIMIT=8, MENU_LIMIT=10, CASH_LIMIT=6, WARN_LIMIT=4):
- Card inserted, no input:
  - active=1 one cycle later.
  - timeout_warn rises 8 cycles after PIN entry.
  - session_abort pulses once 4 cycles later with abort_cause=1.
  - After card_in=0, phase=IDLE.
- key_event every 7 cycles in PIN for 50 cycles -> timeout_warn never asserts.
- In WARN, key_event at warn cycle 2 -> back to PIN with count=0; next warning arrives 8 cycles later.
- pin_ok then cash_presented with no cash_taken:
  - abort 6 cycles after CASH entry with cause=3 and no timeout_warn.
  - key_event during CASH does not delay the abort.
- key_event and expiry in the same cycle in MENU -> no warning; the MENU timer restarts (warning 10 cycles later).
- Reset edge cases:
  - card_in dropped mid-WARN -> IDLE next cycle, session_abort stays 0.
  - rst=0 asserted in MENU -> all outputs 0 on the next edge.
  - rst=0 without a clk edge -> nothing changes.

Source files
------------

// File: rtl/atm_timeout_pkg.sv
// Shared types for the ATM session inactivity timeout controller.
// State encoding doubles as the externally visible phase code.
package atm_timeout_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PIN   = 3'd1,
    S_MENU  = 3'd2,
    S_CASH  = 3'd3,
    S_WARN  = 3'd4,
    S_EJECT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_PIN  = 2'd1,
    CAUSE_MENU = 2'd2,
    CAUSE_CASH = 2'd3
  } cause_t;

  function automatic logic is_timed(state_t s);
    return (s == S_PIN) || (s == S_MENU) ||
           (s == S_CASH) || (s == S_WARN);
  endfunction

endpackage

// File: rtl/atm_cycle_counter.sv
// Saturating cycle counter with a combinational expiry compare.
// Expiry fires when the count reaches limit-1.
module atm_cycle_counter #(
  parameter int CNT_W = atm_timeout_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == (limit - 1'b1));

endmodule

// File: rtl/atm_session_timeout_ctrl.sv
// Inactivity timeout sequencer for one ATM customer session.
// One counter is reloaded with a per-phase limit on every state entry.
module atm_session_timeout_ctrl #(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] PIN_LIMIT  = 32'd30000000,
  parameter logic [CNT_W-1:0] MENU_LIMIT = 32'd60000000,
  parameter logic [CNT_W-1:0] CASH_LIMIT = 32'd30000000,
  parameter logic [CNT_W-1:0] WARN_LIMIT = 32'd10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_in,
  input  logic       key_event,
  input  logic       pin_ok,
  input  logic       cash_presented,
  input  logic       cash_taken,
  output logic       active,
  output logic [2:0] phase,
  output logic       timeout_warn,
  output logic       session_abort,
  output logic [1:0] abort_cause
);

  import atm_timeout_pkg::*;

  state_t           state;
  state_t           state_nxt;
  state_t           resume;
  state_t           resume_nxt;
  cause_t           cause;
  cause_t           cause_nxt;
  logic             restart;
  logic             abort_now;
  logic             expired;
  logic             clear;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit = PIN_LIMIT;
    unique case (state)
      S_MENU:  limit = MENU_LIMIT;
      S_CASH:  limit = CASH_LIMIT;
      S_WARN:  limit = WARN_LIMIT;
      default: limit = PIN_LIMIT;
    endcase
  end

  assign clear = restart || (state_nxt != state);

  atm_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enable  (is_timed(state)),
    .limit   (limit),
    .expired (expired)
  );

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    cause_nxt  = cause;
    restart    = 1'b0;
    abort_now  = 1'b0;
    // Card removal beats everything except reset and never aborts.
    if ((state != S_IDLE) && !card_in) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (card_in) begin
            state_nxt = S_PIN;
            cause_nxt = CAUSE_NONE;
          end
        end
        S_PIN: begin
          if (pin_ok) begin
            state_nxt = S_MENU;
          end else if (key_event) begin
            restart = 1'b1;
          end else if (expired) begin
            state_nxt  = S_WARN;
            resume_nxt = S_PIN;
          end
        end
        S_MENU: begin
          if (cash_presented) begin
            state_nxt = S_CASH;
          end else if (key_event) begin
            restart = 1'b1;
          end else if (expired) begin
            state_nxt  = S_WARN;
            resume_nxt = S_MENU;
          end
        end
        S_CASH: begin
          if (cash_taken) begin
            state_nxt = S_MENU;
          end else if (expired) begin
            state_nxt = S_EJECT;
            abort_now = 1'b1;
            cause_nxt = CAUSE_CASH;
          end
        end
        S_WARN: begin
          if (key_event) begin
            state_nxt = resume;
          end else if (expired) begin
            state_nxt = S_EJECT;
            abort_now = 1'b1;
            cause_nxt = (resume == S_PIN) ? CAUSE_PIN
                                          : CAUSE_MENU;
          end
        end
        S_EJECT: state_nxt = S_EJECT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      resume        <= S_PIN;
      cause         <= CAUSE_NONE;
      active        <= 1'b0;
      timeout_warn  <= 1'b0;
      session_abort <= 1'b0;
    end else begin
      state         <= state_nxt;
      resume        <= resume_nxt;
      cause         <= cause_nxt;
      active        <= is_timed(state_nxt);
      timeout_warn  <= (state_nxt == S_WARN);
      session_abort <= abort_now;
    end
  end

  assign phase       = state;
  assign abort_cause = cause;

endmodule
